// File: rtl/jumpredirect_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jumpredirect_if : fetch PC owner with ID-stage JAL/JALR redirect and squash
// Revision 1.0
// ---------------------------------------------------------------------------
module jumpredirect_if #(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic        jump_isjalr,
  input  logic [31:0] jump_imm,
  input  logic [31:0] jump_base,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush,
  output logic        misalign_exc,
  output logic        halted
);
  localparam int            CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int            PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] squash;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   addr_fifo [MAX_OUTSTANDING];

  logic [31:0]   target_sum;
  logic [31:0]   target;
  logic          target_ok;
  logic          jump_run;
  logic          accept;
  logic          resp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    target_sum = jump_base + jump_imm;
    target     = {target_sum[31:1], target_sum[0] & ~jump_isjalr};
  end

  assign target_ok   = (target[1:0] == 2'b00);
  assign jump_run    = jump_valid && (state == ST_RUN);
  assign fetch_valid = !rst && (state == ST_RUN) && !stall && !jump_valid &&
                       (outstanding < MAX_CNT);
  assign fetch_addr  = pc;
  assign accept      = fetch_valid && fetch_ready;
  // Responses with nothing tracked belong to requests issued before a reset.
  assign resp        = imem_rvalid && (outstanding != '0);
  assign halted      = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_fifo[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      pc           <= RESET_VECTOR;
      outstanding  <= '0;
      squash       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      instr_valid  <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      flush        <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      flush        <= 1'b0;
      misalign_exc <= 1'b0;
      instr_valid  <= 1'b0;

      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
        pc     <= pc + 32'd4;
      end

      if (resp) begin
        rd_ptr <= ptr_inc(rd_ptr);
        if (squash != '0) begin
          squash <= squash - CW'(1);
        end else if ((state == ST_RUN) && !jump_valid) begin
          instr_valid <= 1'b1;
          instr       <= imem_rdata;
          instr_pc    <= addr_fifo[rd_ptr];
        end
      end

      outstanding <= outstanding + CW'(accept) - CW'(resp);

      // A jump squashes every in-flight response except one consumed right now.
      if (jump_run) begin
        squash <= outstanding - CW'(resp);
        if (target_ok) begin
          pc    <= target;
          flush <= 1'b1;
        end else begin
          misalign_exc <= 1'b1;
          state        <= ST_HALT;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/jumpredirect_if.md
Name: jumpredirect_if

Overview:
- Fetch-side receiver of the ID-stage jump target path (JAL/JALR immediate plus base).
- Holds the architectural fetch PC and issues sequential fetches to instruction memory over a valid/ready handshake.
- On a jump from ID, forms the final target, redirects fetch, and squashes wrong-path responses still in flight.
- Flags misaligned targets and halts fetch until reset.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered fetches (1..3).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from ID; no new fetch is issued while high.
- jump_valid  input  1  ID presents a JAL/JALR this cycle; single-cycle pulse.
- jump_isjalr  input  1  1 = JALR (clear target bit 0), 0 = JAL.
- jump_imm  input  32  sign-extended jump immediate from ID.
- jump_base  input  32  rs1 for JALR, instruction PC for JAL.
- fetch_valid  output  1  fetch request valid.
- fetch_ready  input  1  imem accepts the request when valid && ready.
- fetch_addr  output  32  word address of the request (= pc).
- imem_rvalid  input  1  in-order response valid.
- imem_rdata  input  32  response instruction word.
- instr_valid  output  1  forwarded instruction valid to ID.
- instr  output  32  forwarded instruction word.
- instr_pc  output  32  address of the forwarded instruction.
- flush  output  1  one-cycle pulse: ID must discard its current instruction.
- misalign_exc  output  1  one-cycle pulse when a target is misaligned.
- halted  output  1  high in HALT state.

Behaviour:
- Reset values:
  - pc = RESET_VECTOR; state = RUN.
  - outstanding = 0; squash = 0.
  - fetch_valid, instr_valid, flush, misalign_exc, halted = 0.
  - instr = 0; instr_pc = 0.
- Target formation: target = (jump_base + jump_imm) mod 2^32. If jump_isjalr, bit 0 is forced to 0. Overflow wraps silently.
- States:
  - RUN: fetch_valid = !stall && outstanding < MAX_OUTSTANDING && !jump_valid. On acceptance, pc += 4 (wraps at 2^32) and outstanding++.
  - HALT: fetch_valid = 0 and halted = 1. Responses still drain and are discarded. Only rst leaves HALT.
- Response tracking:
  - Per-response address FIFO of depth MAX_OUTSTANDING, pushed with fetch_addr on acceptance.
  - On imem_rvalid: pop the FIFO and decrement outstanding.
  - If squash > 0, decrement squash and drop the response.
  - Otherwise register it as instr_valid = 1, instr = imem_rdata, instr_pc = popped address, one cycle after imem_rvalid.
  - Acceptance and response in the same cycle leave outstanding unchanged.
- Jump in RUN, target[1:0] == 0:
  - pc <= target; flush = 1 next cycle.
  - squash <= outstanding minus (1 if imem_rvalid this cycle).
  - No fetch is issued in the jump cycle.
  - The first target fetch is issued no earlier than the cycle after jump_valid.
  - Any instr_valid that would fire in the flush cycle is suppressed.
- Jump in RUN, target[1:0] != 0:
  - misalign_exc = 1 next cycle; state <= HALT; pc unchanged.
  - squash <= all outstanding responses.
- Stall and jump together: jump wins; the redirect is still taken.
- Jump in HALT: ignored.
- rst mid-operation:
  - All counters and the FIFO clear.
  - Responses arriving after reset for pre-reset requests are not tracked (imem is reset with the core).
- Latency: fetch acceptance to instr_valid is imem latency + 1 cycle. jump_valid to the first fetch_valid at the target is 1 cycle.

Test Plan:
- Reset, then fetch_ready = 1 and a 1-cycle imem: fetch_addr sequence 0x0, 0x4, 0x8. instr_pc matches, instr_valid every cycle after fill.
- JAL with jump_base = 0x100, jump_imm = 0x40 while 2 fetches are outstanding: flush pulse, 2 responses dropped, next fetch_addr = 0x140, first instr_pc = 0x140.
- JALR with jump_base = 0x203, jump_imm = 0x1: target 0x204 (bit 0 cleared, alignment OK), redirect with no exception. With jump_imm = 0x3: target 0x206, misalign_exc pulse, halted = 1, fetch_valid = 0 thereafter.
- fetch_ready = 0 for 5 cycles: fetch_valid held, fetch_addr stable, pc not advanced. stall = 1: fetch_valid = 0 and pc held.
- jump_imm = 32'hFFFF_FFFC with jump_base = 0x0: target 0xFFFF_FFFC. Next fetch wraps pc to 0x0.
- rst asserted in HALT with 1 outstanding: next cycle pc = RESET_VECTOR, halted = 0, outstanding = 0, fetch resumes at RESET_VECTOR.
